button_press_detector: RTL and testbench

Parametrised successor to the four-button monitor. It synchronises and debounces `NUM_BUTTONS` raw push-button inputs, then emits one single-cycle press pulse per qualified press. It also provides a per-button held level and an optional hold-to-repeat mode. It sits between the board KEY pins and the lock-entry FSM, which consumes `buttonPresses` exactly as before.

---
 rtl/button_pkg.sv | 16 +
 rtl/button_debounce_channel.sv | 154 +++++++++++++++
 rtl/button_press_detector.sv | 52 +++++
 tb/tb_button_press_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button debounce/press-detect block.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } chan_state_e;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop sync, debounce FSM, optional repeat timer (BUTTON_REPEAT_EN).
// Press pulse DEBOUNCE_CYCLES+2 edges after raw press; no backpressure, pulses are fire-and-forget.
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press_nxt,
    output logic press,
    output logic held
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d, held_q, held_d;
    logic          press_entry, rpt_fire;
    logic          pressed;

    assign pressed = sync2_q;

    always_comb begin
        sync1_d = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
        sync2_d = sync1_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_entry = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pressed) begin
                    state_d = PRESS_DB;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_DB: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    press_entry = 1'b1;
                end else if (cnt_q != DB_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = REL_DB;
                    cnt_d   = CW'(1);
                end
            end
            REL_DB: begin
                // A re-press during release debounce resumes HELD silently.
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != DB_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == HELD) || (state_d == REL_DB);
    end

`ifdef BUTTON_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_first_q, rpt_first_d;

    always_comb begin
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        if (state_q == PRESS_DB && state_d == HELD) begin
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end else if ((state_q == HELD || state_q == REL_DB) && state_d != IDLE) begin
            if (rpt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
                rpt_fire    = 1'b1;
                rpt_d       = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end else begin
            rpt_d       = '0;
            rpt_first_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign press_d = press_entry | rpt_fire;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            held_q  <= held_d;
        end
    end

    assign press_nxt = press_d;
    assign press     = press_q;
    assign held      = held_q;

endmodule

// File: rtl/button_press_detector.sv
// NUM_BUTTONS debounced press detectors plus a registered any-press flag; BUTTON_REPEAT_EN adds hold-to-repeat.
// Press pulse DEBOUNCE_CYCLES+2 edges after raw press, all outputs registered; no backpressure.
module button_press_detector
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] buttonPresses,
    output logic [NUM_BUTTONS-1:0] buttonHeld,
    output logic                   anyPress
);

    logic [NUM_BUTTONS-1:0] press_nxt;
    logic                   any_press_q, any_press_d;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .btn_raw   (buttons[gi]),
            .press_nxt (press_nxt[gi]),
            .press     (buttonPresses[gi]),
            .held      (buttonHeld[gi])
        );
    end

    // Built from the channels' next-state pulses so it lines up with buttonPresses.
    assign any_press_d = |press_nxt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign anyPress = any_press_q;

endmodule

// File: tb/tb_button_press_detector.sv
// Bench for button_press_detector: directed scenarios plus random toggling against a run-length reference model.
module tb_button_press_detector;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef BUTTON_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] buttons = '1;
    logic [NB-1:0] presses, held;
    logic          any_press;

    button_press_detector #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock         (clk),
        .reset         (rst_n),
        .buttons       (buttons),
        .buttonPresses (presses),
        .buttonHeld    (held),
        .anyPress      (any_press)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference: a channel's accepted level flips once the synced input has
    // disagreed with it for DB consecutive edges; rising flips pulse, and with
    // repeat on, pulses also land at t = RD, RD+RP, RD+2RP... edges after entry.
    logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_acc = '0, m_press = '0;
    int m_run [NB];
    int m_t   [NB];

    task automatic model_edge();
        logic [NB-1:0] norm;
        norm    = ~buttons;
        m_press = '0;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_acc = '0;
            for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_t[c] = 0; end
            return;
        end
        for (int c = 0; c < NB; c++) begin
            if (m_s2[c] != m_acc[c]) m_run[c]++;
            else                     m_run[c] = 0;
            if (m_run[c] == DB) begin
                m_acc[c] = ~m_acc[c];
                m_run[c] = 0;
                if (m_acc[c]) begin
                    m_press[c] = 1'b1;
                    m_t[c]     = 0;
                end
            end else if (m_acc[c]) begin
                m_t[c]++;
                if (RPT_EN && (m_t[c] == RD || (m_t[c] > RD && (m_t[c] - RD) % RP == 0)))
                    m_press[c] = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = norm;
    endtask

    int            pulse_cnt  [NB];
    int            pulse_edge [NB];
    int            held_fall  [NB];
    logic [NB-1:0] prev_held = '0;
    logic [NB-1:0] sim_vec;
    logic          sim_any;
    int            sim_edge;
    bit            sim_seen;

    task automatic clr_mon();
        for (int c = 0; c < NB; c++) begin
            pulse_cnt[c] = 0; pulse_edge[c] = -1; held_fall[c] = -1;
        end
        sim_seen = 1'b0; sim_vec = '0; sim_any = 1'b0; sim_edge = -1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("presses", 32'(presses), 32'(m_press));
        chk("held", 32'(held), 32'(m_acc));
        chk("any_press", 32'(any_press), 32'(|m_press));
        for (int c = 0; c < NB; c++) begin
            if (presses[c]) begin pulse_cnt[c]++; pulse_edge[c] = cyc; end
            if (prev_held[c] && !held[c]) held_fall[c] = cyc;
        end
        if (!sim_seen && |presses) begin
            sim_seen = 1'b1; sim_vec = presses; sim_any = any_press; sim_edge = cyc;
        end
        prev_held = held;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int lim_tab [3];
        lim_tab[0] = 2; lim_tab[1] = 10; lim_tab[2] = 60;
        clr_mon();

        // Reset
        rst_n = 1'b0; buttons = '1;
        run(2);
        chk("rst_presses", 32'(presses), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_any", 32'(any_press), 32'd0);
        rst_n = 1'b1;
        run(3);

        // Clean press on button 0, held 30 cycles
        clr_mon(); e0 = cyc;
        buttons = 4'b1110; run(30);
        chk("clean_latency", 32'(pulse_edge[0] < 0 ? -1 : 0) == 0 ? 32'(pulse_cnt[0] > 0 ? (RPT_EN ? 0 : pulse_edge[0] - e0) : -1) : 32'hFFFF_FFFF,
            RPT_EN ? 32'd0 : 32'd6);
        buttons = 4'b1111; run(15);
        chk("clean_count", 32'(pulse_cnt[0]), RPT_EN ? 32'd3 : 32'd1);
        chk("clean_release", 32'(held_fall[0] - e0), 32'd36);

        // Bounce on button 1: 0,1,0,1 then stays 0
        run(5);
        clr_mon(); e0 = cyc;
        buttons[1] = 1'b0; step();
        buttons[1] = 1'b1; step();
        buttons[1] = 1'b0; step();
        buttons[1] = 1'b1; step();
        buttons[1] = 1'b0; run(12);
        chk("bounce_count", 32'(pulse_cnt[1]), 32'd1);
        chk("bounce_latency", 32'(pulse_edge[1] - e0), 32'd10);
        buttons = 4'b1111; run(10);

        // Simultaneous press on all buttons
        clr_mon(); e0 = cyc;
        buttons = 4'b0000; run(10);
        chk("simul_vec", 32'(sim_vec), 32'hF);
        chk("simul_any", 32'(sim_any), 32'd1);
        chk("simul_latency", 32'(sim_edge - e0), 32'd6);
        buttons = 4'b1111; run(10);

        // Release glitch on held button 2
        clr_mon();
        buttons = 4'b1011; run(8);
        buttons = 4'b1111; run(2);
        buttons = 4'b1011; run(6);
        chk("glitch_count", 32'(pulse_cnt[2]), 32'd1);
        chk("glitch_held", 32'(held[2]), 32'd1);
        chk("glitch_no_fall", 32'(held_fall[2]), 32'hFFFF_FFFF);
        buttons = 4'b1111; run(10);

        // Reset mid-debounce on button 3 (count = 3 after 5 edges)
        clr_mon();
        buttons = 4'b0111; run(5);
        rst_n = 1'b0; step();
        chk("mid_rst_presses", 32'(presses), 32'd0);
        chk("mid_rst_held", 32'(held), 32'd0);
        chk("mid_rst_any", 32'(any_press), 32'd0);
        rst_n = 1'b1; e0 = cyc; run(10);
        chk("mid_rst_count", 32'(pulse_cnt[3]), 32'd1);
        chk("mid_rst_latency", 32'(pulse_edge[3] - e0), 32'd6);
        buttons = 4'b1111; run(10);

        // Long hold on button 0
        clr_mon(); e0 = cyc;
        buttons = 4'b1110; run(50);
        chk("repeat_count", 32'(pulse_cnt[0]), RPT_EN ? 32'd5 : 32'd1);
        chk("repeat_last", 32'(pulse_edge[0] - e0), RPT_EN ? 32'd50 : 32'd6);
        buttons = 4'b1111; run(12);

        // Random toggling at three activity levels with occasional resets
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 300; i++) begin
                for (int c = 0; c < NB; c++)
                    if ($urandom_range(0, lim_tab[s]) == 0) buttons[c] = ~buttons[c];
                rst_n = ($urandom_range(0, 199) != 0);
                step();
            end
        end
        rst_n = 1'b1;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
